// File: rtl/multi_lfsr_prng_if.sv
// rtl/multi_lfsr_prng_if.sv - seed/mode/output bundle for multi_lfsr_prng
//
// Purpose: groups the seed, control and valid/ready output signals of the
// generator so they travel as one port.
// Signals:
//   i_seed_in     seed value
//   i_seed_valid  load i_seed_in this cycle, always accepted
//   i_mode        0=XOR all, 1=round-robin, 2=single LFSR, 3=as 0
//   i_sel         LFSR index for mode 2
//   i_out_ready   consumer accepts o_out_data
//   o_out_data    random word
//   o_out_valid   o_out_data holds an unconsumed word
//   o_busy        high during warm-up
// Modports: master drives the controls and consumes data, slave is the generator.
interface multi_lfsr_prng_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] i_seed_in;
  logic             i_seed_valid;
  logic [1:0]       i_mode;
  logic [1:0]       i_sel;
  logic             i_out_ready;
  logic [WIDTH-1:0] o_out_data;
  logic             o_out_valid;
  logic             o_busy;

  modport master (
    output i_seed_in, i_seed_valid, i_mode, i_sel, i_out_ready,
    input  o_out_data, o_out_valid, o_busy
  );

  modport slave (
    input  i_seed_in, i_seed_valid, i_mode, i_sel, i_out_ready,
    output o_out_data, o_out_valid, o_busy
  );
endinterface

// File: rtl/multi_lfsr_prng.sv
// rtl/multi_lfsr_prng.sv - multi Galois-LFSR random word generator
//
// Purpose: runs NUM_LFSR right-shift Galois LFSRs of WIDTH bits, each with its
// own feedback mask, and emits one combined word per accepted transfer.
// Output is the XOR of all LFSRs, a round-robin pick, or one selected LFSR.
// A seed load restarts everything and is followed by WARMUP free-running
// steps before words are produced.
// Ports:
//   i_clk  clock, rising edge
//   i_rst  asynchronous reset, active-high
//   bus    multi_lfsr_prng_if slave modport (seed, mode/sel, valid/ready output)
module multi_lfsr_prng #(
  parameter int          WIDTH    = 16,
  parameter int          NUM_LFSR = 4,
  parameter logic [31:0] POLY0    = 32'h0000_B400,
  parameter logic [31:0] POLY1    = 32'h0000_8016,
  parameter logic [31:0] POLY2    = 32'h0000_801C,
  parameter logic [31:0] POLY3    = 32'h0000_801F,
  parameter int          WARMUP   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  multi_lfsr_prng_if.slave  bus
);

  localparam logic [WIDTH-1:0] POLY [4] = '{
    POLY0[WIDTH-1:0], POLY1[WIDTH-1:0], POLY2[WIDTH-1:0], POLY3[WIDTH-1:0]
  };
  localparam logic [15:0] WARMUP_N = WARMUP[15:0];
  localparam logic [1:0]  RR_LAST  = 2'(NUM_LFSR - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t           r_state;
  // Always four slots; slots at or above NUM_LFSR stay at zero so the
  // round-robin and select muxes can index with a plain 2-bit value.
  logic [WIDTH-1:0] r_lfsr [4];
  logic [15:0]      r_cnt;
  logic [1:0]       r_rr;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_busy;

  logic [WIDTH-1:0] w_seed0;
  logic [WIDTH-1:0] w_seeded [4];
  logic [WIDTH-1:0] w_step [4];
  logic [WIDTH-1:0] w_xor;
  logic [WIDTH-1:0] w_word;
  logic [1:0]       w_sel_idx;
  logic [1:0]       w_rr_next;
  logic [15:0]      w_cnt_next;
  logic             w_advance;

  // Rotate left by n bit positions within WIDTH.
  function automatic logic [WIDTH-1:0] f_rotl(input logic [WIDTH-1:0] x, input int n);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int b = 0; b < WIDTH; b++) begin
      r[(b + n) % WIDTH] = x[b];
    end
    return r;
  endfunction

  always_comb begin
    // A zero seed would lock every LFSR at zero, so it is promoted to 1.
    w_seed0 = (bus.i_seed_in == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : bus.i_seed_in;

    for (int i = 0; i < 4; i++) begin
      w_seeded[i] = f_rotl(w_seed0, (4 * i) % WIDTH);
      w_step[i]   = (r_lfsr[i] >> 1) ^ (r_lfsr[i][0] ? POLY[i] : '0);
    end

    w_xor = '0;
    for (int i = 0; i < NUM_LFSR; i++) begin
      w_xor = w_xor ^ w_step[i];
    end

    w_sel_idx = (int'(bus.i_sel) < NUM_LFSR) ? bus.i_sel : 2'd0;

    case (bus.i_mode)
      2'd1:    w_word = w_step[r_rr];
      2'd2:    w_word = w_step[w_sel_idx];
      default: w_word = w_xor;
    endcase

    w_rr_next  = (r_rr == RR_LAST) ? 2'd0 : r_rr + 2'd1;
    w_cnt_next = r_cnt + 16'd1;
    // A word is produced when the output slot is empty or being drained.
    w_advance  = !r_out_valid || bus.i_out_ready;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      for (int i = 0; i < 4; i++) begin
        r_lfsr[i] <= '0;
      end
      r_cnt       <= '0;
      r_rr        <= 2'd0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (bus.i_seed_valid) begin
      // Seeding wins in every state and discards any pending word;
      // out_data keeps its last value.
      for (int i = 0; i < 4; i++) begin
        r_lfsr[i] <= (i < NUM_LFSR) ? w_seeded[i] : '0;
      end
      r_cnt       <= '0;
      r_rr        <= 2'd0;
      r_out_valid <= 1'b0;
      if (WARMUP_N == 16'd0) begin
        r_state <= ST_RUN;
        r_busy  <= 1'b0;
      end else begin
        r_state <= ST_WARMUP;
        r_busy  <= 1'b1;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_out_valid <= 1'b0;
        end
        ST_WARMUP: begin
          for (int i = 0; i < 4; i++) begin
            r_lfsr[i] <= (i < NUM_LFSR) ? w_step[i] : '0;
          end
          r_cnt <= w_cnt_next;
          if (w_cnt_next == WARMUP_N) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_advance) begin
            for (int i = 0; i < 4; i++) begin
              r_lfsr[i] <= (i < NUM_LFSR) ? w_step[i] : '0;
            end
            r_out_data  <= w_word;
            r_out_valid <= 1'b1;
            if (bus.i_mode == 2'd1) begin
              r_rr <= w_rr_next;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_out_data  = r_out_data;
  assign bus.o_out_valid = r_out_valid;
  assign bus.o_busy      = r_busy;

endmodule

// File: tb/tb_multi_lfsr_prng.sv
// tb/tb_multi_lfsr_prng.sv - self-checking bench for multi_lfsr_prng
module tb_multi_lfsr_prng;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  multi_lfsr_prng_if #(.WIDTH(16)) ifa ();
  multi_lfsr_prng_if #(.WIDTH(16)) ifb ();

  // Default configuration: 4 LFSRs, 16-step warm-up.
  multi_lfsr_prng #(.WIDTH(16)) dut_a (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (ifa)
  );

  // Single LFSR, no warm-up.
  multi_lfsr_prng #(.WIDTH(16), .NUM_LFSR(1), .WARMUP(0)) dut_b (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (ifb)
  );

  // Reference model for dut_a: four 16-bit LFSR states and a round-robin index.
  int unsigned m [4];
  int unsigned polys [4] = '{32'hB400, 32'h8016, 32'h801C, 32'h801F};
  int          m_rr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_seed(input int unsigned sd);
    int unsigned s0;
    int          n;
    s0 = (sd == 0) ? 1 : sd;
    for (int i = 0; i < 4; i++) begin
      n    = (4 * i) % 16;
      m[i] = ((s0 << n) | (s0 >> (16 - n))) & 32'hFFFF;
    end
    m_rr = 0;
  endtask

  task automatic model_adv();
    for (int i = 0; i < 4; i++) begin
      m[i] = ((m[i] >> 1) ^ (((m[i] & 1) != 0) ? polys[i] : 0)) & 32'hFFFF;
    end
  endtask

  task automatic model_word(input int md, input int sl, output logic [15:0] w);
    int unsigned acc;
    model_adv();
    acc = 0;
    if (md == 1) begin
      acc  = m[m_rr];
      m_rr = (m_rr + 1) % 4;
    end else if (md == 2) begin
      acc = m[sl];
    end else begin
      for (int i = 0; i < 4; i++) acc = acc ^ m[i];
    end
    w = acc[15:0];
  endtask

  task automatic seed_a(input logic [15:0] v);
    ifa.i_seed_in    = v;
    ifa.i_seed_valid = 1'b1;
    tick();
    ifa.i_seed_valid = 1'b0;
    model_seed(v);
  endtask

  task automatic seed_b(input logic [15:0] v);
    ifb.i_seed_in    = v;
    ifb.i_seed_valid = 1'b1;
    tick();
    ifb.i_seed_valid = 1'b0;
  endtask

  logic [15:0]    exp_b [4] = '{16'hB400, 16'h5A00, 16'h2D00, 16'h1680};
  bit   [65535:0] seen;
  logic [15:0]    w;
  logic [15:0]    first_w;
  logic [15:0]    prev_d;
  logic           prev_v;
  logic           r;

  initial begin
    ifa.i_seed_in = '0; ifa.i_seed_valid = 1'b0; ifa.i_mode = 2'd0; ifa.i_sel = 2'd0; ifa.i_out_ready = 1'b1;
    ifb.i_seed_in = '0; ifb.i_seed_valid = 1'b0; ifb.i_mode = 2'd2; ifb.i_sel = 2'd0; ifb.i_out_ready = 1'b1;

    // Reset state and IDLE hold.
    #12;
    chk("rst_valid", ifa.o_out_valid, 0);
    chk("rst_data",  ifa.o_out_data,  0);
    chk("rst_busy",  ifa.o_busy,      0);
    rst = 1'b0;
    repeat (3) tick();
    chk("idle_valid", ifa.o_out_valid, 0);
    chk("idle_busy",  ifa.o_busy,      0);

    // Single LFSR known sequence, seed 1 then seed 0 with out-of-range sel.
    seed_b(16'h0001);
    chk("b_seed_valid", ifb.o_out_valid, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("b_seq_valid", ifb.o_out_valid, 1);
      chk("b_seq_data",  ifb.o_out_data,  exp_b[k]);
    end
    ifb.i_sel = 2'd2;
    seed_b(16'h0000);
    chk("b_reseed_valid", ifb.o_out_valid, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("b_seed0_data", ifb.o_out_data, exp_b[k]);
    end

    // Full period: 65535 distinct nonzero words, then wrap.
    ifb.i_mode = 2'd0;
    seed_b(16'h2855);
    seen = '0;
    for (int k = 1; k <= 65535; k++) begin
      tick();
      w = ifb.o_out_data;
      if (k == 1) first_w = w;
      chk("b_period_word", {29'd0, ifb.o_out_valid, (w != 16'd0), seen[w]}, 32'd6);
      seen[w] = 1'b1;
    end
    tick();
    chk("b_period_wrap", ifb.o_out_data, first_w);

    // Warm-up length and latency.
    ifa.i_mode = 2'd0;
    seed_a(16'h2855);
    for (int c = 0; c < 16; c++) begin
      chk("wu_busy",  ifa.o_busy,      1);
      chk("wu_valid", ifa.o_out_valid, 0);
      tick();
    end
    chk("wu_busy_end",  ifa.o_busy,      0);
    chk("wu_valid_end", ifa.o_out_valid, 0);
    repeat (16) model_adv();
    tick();
    model_word(0, 0, w);
    chk("wu_first_valid", ifa.o_out_valid, 1);
    chk("wu_first_data",  ifa.o_out_data,  w);

    // Reseed mid-warm-up restarts the count.
    seed_a(16'h2855);
    repeat (7) tick();
    chk("rs_mid_busy", ifa.o_busy, 1);
    seed_a(16'h1234);
    for (int c = 0; c < 16; c++) begin
      chk("rs_valid_low", ifa.o_out_valid, 0);
      tick();
    end
    chk("rs_valid_low_end", ifa.o_out_valid, 0);
    repeat (16) model_adv();
    tick();
    model_word(0, 0, w);
    chk("rs_first_valid", ifa.o_out_valid, 1);
    chk("rs_first_data",  ifa.o_out_data,  w);

    // Round-robin, then mode switches mid-stream.
    ifa.i_mode = 2'd1;
    seed_a(16'h2855);
    repeat (16) tick();
    repeat (16) model_adv();
    for (int k = 0; k < 12; k++) begin
      tick();
      model_word(1, 0, w);
      chk("rr_data", ifa.o_out_data, w);
    end
    ifa.i_mode = 2'd0;
    for (int k = 0; k < 4; k++) begin
      tick();
      model_word(0, 0, w);
      chk("rr_to_xor", ifa.o_out_data, w);
    end
    ifa.i_mode = 2'd2;
    ifa.i_sel  = 2'd3;
    for (int k = 0; k < 2; k++) begin
      tick();
      model_word(2, 3, w);
      chk("sel3_data", ifa.o_out_data, w);
    end
    ifa.i_mode = 2'd3;
    for (int k = 0; k < 2; k++) begin
      tick();
      model_word(3, 0, w);
      chk("mode3_data", ifa.o_out_data, w);
    end

    // Random back-pressure: accepted stream must equal the unthrottled stream.
    ifa.i_mode = 2'd0;
    seed_a(16'h2855);
    repeat (16) tick();
    repeat (16) model_adv();
    for (int k = 0; k < 400; k++) begin
      prev_v = ifa.o_out_valid;
      prev_d = ifa.o_out_data;
      r = 1'($urandom_range(0, 1));
      ifa.i_out_ready = r;
      tick();
      if (prev_v && r) begin
        model_word(0, 0, w);
        chk("bp_accept", prev_d, w);
      end else if (prev_v) begin
        chk("bp_hold", {15'd0, ifa.o_out_valid, ifa.o_out_data}, {15'd0, 1'b1, prev_d});
      end
    end

    // Reseed in RUN while stalled: pending word dropped, data held.
    ifa.i_out_ready = 1'b0;
    tick();
    chk("stall_valid", ifa.o_out_valid, 1);
    prev_d = ifa.o_out_data;
    seed_a(16'h0777);
    chk("rsrun_valid", ifa.o_out_valid, 0);
    chk("rsrun_data",  ifa.o_out_data,  prev_d);
    chk("rsrun_busy",  ifa.o_busy,      1);

    // Asynchronous reset mid-RUN.
    ifa.i_out_ready = 1'b1;
    repeat (17) tick();
    chk("pre_rst_valid", ifa.o_out_valid, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", ifa.o_out_valid, 0);
    chk("arst_data",  ifa.o_out_data,  0);
    chk("arst_busy",  ifa.o_busy,      0);
    #2;
    rst = 1'b0;
    repeat (5) tick();
    chk("post_rst_valid", ifa.o_out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_lfsr_prng.md
Name: multi_lfsr_prng

Overview:
Parametrised successor to the fixed 16-bit multi-LFSR generator. It runs NUM_LFSR right-shift Galois LFSRs of WIDTH bits, each with its own polynomial. Output is selectable: XOR of all LFSRs, round-robin interleave, or a single LFSR. Adds a reseed path, a configurable warm-up period and a valid/ready output stage, so downstream logging and consumers can apply back-pressure without losing sequence.

Parameters:
WIDTH, 16, LFSR and output width (8..32).
NUM_LFSR, 4, number of LFSRs instantiated (1..4).
POLY0, 16'hB400, Galois feedback mask for LFSR0. Must be maximal for WIDTH.
POLY1, 16'h8016, feedback mask for LFSR1.
POLY2, 16'h801C, feedback mask for LFSR2.
POLY3, 16'h801F, feedback mask for LFSR3.
WARMUP, 16, free-running steps after reseed before output is enabled (0..65535).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
seed_in  in  WIDTH  seed value
seed_valid  in  1  load seed_in this cycle; always accepted
mode  in  2  0=XOR all, 1=round-robin, 2=single LFSR (sel), 3=reserved, behaves as 0
sel  in  2  LFSR index for mode 2; sel>=NUM_LFSR selects LFSR0
out_ready  in  1  consumer accepts out_data
out_data  out  WIDTH  random word
out_valid  out  1  out_data holds an unconsumed word
busy  out  1  high in WARMUP

Behaviour:
- Reset (async, rst=1): state=IDLE, all LFSRs=0, warmup counter=0, rr pointer=0, out_data=0, out_valid=0, busy=0.
- step(s) = (s>>1) ^ (s[0] ? POLYi : 0), truncated to WIDTH.
- Seeding:
  - Let s0 = (seed_in==0) ? 1 : seed_in.
  - LFSR i loads s0 rotated left by 4*i (mod WIDTH).
  - At the same edge: rr pointer=0, warmup counter=0, out_valid<=0, out_data is held.
  - Next state is WARMUP, or RUN if WARMUP==0.
- seed_valid has priority over every other action, in every state including mid-warmup and RUN. Any pending unconsumed word is discarded.
- IDLE: LFSRs are frozen and out_valid=0. The only exit is seed_valid.
- WARMUP:
  - Every edge: all LFSRs step and the counter increments.
  - When the counter reaches WARMUP, the state moves to RUN on that same edge.
  - busy=1 throughout.
- RUN, advance condition = !out_valid || out_ready. On an advancing edge:
  - Every LFSR_i <= step(LFSR_i).
  - out_data <= combine(stepped values).
  - out_valid <= 1.
  - In mode 1, rr pointer <= (rr+1) mod NUM_LFSR.
- No advance: LFSRs, out_data and the pointer are held. The stream is gap-free under back-pressure.
- combine():
  - mode 0/3: XOR of all stepped LFSRs.
  - mode 1: stepped LFSR[rr].
  - mode 2: stepped LFSR[sel].
- mode and sel are sampled on each advancing edge. A change affects only subsequently generated words.
- Latency: seed_valid at edge T; first out_valid=1 after edge T+WARMUP+1.
- Throughput: one word per cycle while out_ready=1.
- No LFSR ever reaches 0 (nonzero seed and maximal polynomials). Period per LFSR is 2^WIDTH-1.

Test Plan:
1. Reset: assert rst mid-RUN, asynchronous to clk -> out_valid=0, out_data=0, busy=0 immediately. No output until the next seed_valid.
2. NUM_LFSR=1, WARMUP=0, mode=2, sel=0, seed 0x0001, out_ready=1 -> out_data sequence 0xB400, 0x5A00, 0x2D00, 0x1680, first valid one cycle after seed. seed 0x0000 -> identical sequence.
3. Period: NUM_LFSR=1, seed 0x2855, WARMUP=0 -> 65535 consecutive words all distinct and nonzero; word 65536 equals word 1.
4. Back-pressure: default params, seed 0x2855, mode 0, toggle out_ready pseudo-randomly -> accepted word stream is identical to the out_ready=1 run. out_data is stable while out_valid && !out_ready.
5. Warm-up/reseed: WARMUP=16, seed at T -> busy high for 16 cycles, first valid after edge T+17. A second seed_valid at T+8 restarts the count and the first valid follows that seed by 17 edges. Reseed during RUN with out_ready=0 -> out_valid drops the next cycle.
6. Mode 1, NUM_LFSR=4, seed 0x2855, WARMUP=0 -> word k equals the model's stepped LFSR[k mod 4]. Switch to mode 0 mid-stream -> the next generated word is the XOR of the four.
